dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester (CPU = m0, DMA = m1) round-robin arbiter in front
// of a single-port, word-addressed data memory with combinational read data.
// Loads and full-word stores complete one cycle after acceptance. Partial
// stores take two: a read pass that merges the enabled byte lanes, then a
// single write of the merged word.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   mX_req/we/addr/wdata/be request from requester X (X = 0 CPU, 1 DMA)
//   mX_gnt                  one-cycle completion pulse for requester X
//   mX_rdata                registered load data for requester X
//   busy                    high whenever the FSM is not idle
//   mem_wr_en/addr/wdata    memory write port (mem_addr also drives the read)
//   mem_rdata               same-cycle memory read data for mem_addr
module dmem_arbiter #(
    parameter int unsigned NUM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        busy,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned WADDR_W = 30;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        MERGE_WR = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 win_q, win_d;
    logic                 we_q, we_d;
    logic [WADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [BE_W-1:0]      be_q, be_d;
    logic [DATA_W-1:0]    merged_q, merged_d;
    logic [DATA_W-1:0]    m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]    m1_rdata_q, m1_rdata_d;
    logic                 m0_gnt_q, m0_gnt_d;
    logic                 m1_gnt_q, m1_gnt_d;
    logic                 busy_q, busy_d;
    logic                 mem_wr_en_q, mem_wr_en_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;

    // Arbitration result and the winner's request fields, valid in IDLE
    logic                 sel_m1_c;
    logic                 sel_we_c;
    logic [WADDR_W-1:0]   sel_waddr_c;
    logic [DATA_W-1:0]    sel_wdata_c;
    logic [BE_W-1:0]      sel_be_c;
    logic [DATA_W-1:0]    merge_c;

    // Byte-offset bits never reach the memory; words are always aligned
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{m0_addr[1:0], m1_addr[1:0]};

    // Round-robin: a lone requester wins, a tie goes to the one not granted last
    always_comb begin
        sel_m1_c = 1'b0;
        if (m0_req && m1_req) begin
            sel_m1_c = ~last_grant_q;
        end else begin
            sel_m1_c = m1_req;
        end
        sel_we_c    = sel_m1_c ? m1_we : m0_we;
        sel_waddr_c = sel_m1_c ? m1_addr[31:2] : m0_addr[31:2];
        sel_wdata_c = sel_m1_c ? m1_wdata : m0_wdata;
        sel_be_c    = sel_m1_c ? m1_be : m0_be;
    end

    // Per-lane merge of store data over the current memory word
    always_comb begin
        merge_c = '0;
        for (int i = 0; i < int'(BE_W); i++) begin
            merge_c[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem_rdata[8*i +: 8];
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        win_d        = win_q;
        we_d         = we_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        merged_d     = merged_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        m0_gnt_d     = 1'b0;
        m1_gnt_d     = 1'b0;
        mem_wr_en_d  = 1'b0;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    win_d   = sel_m1_c;
                    we_d    = sel_we_c;
                    waddr_d = sel_waddr_c;
                    wdata_d = sel_wdata_c;
                    be_d    = sel_be_c;
                    state_d = ACCESS;
                    // Full-word stores write during ACCESS, so arm the strobe now
                    if (sel_we_c && (sel_be_c == 4'b1111)) begin
                        mem_wr_en_d = 1'b1;
                        mem_wdata_d = sel_wdata_c;
                    end
                end
            end

            ACCESS: begin
                if (!we_q) begin
                    if (win_q) begin
                        m1_rdata_d = mem_rdata;
                    end else begin
                        m0_rdata_d = mem_rdata;
                    end
                    m0_gnt_d     = ~win_q;
                    m1_gnt_d     = win_q;
                    last_grant_d = win_q;
                    state_d      = IDLE;
                end else if ((be_q == 4'b1111) || (be_q == 4'b0000)) begin
                    m0_gnt_d     = ~win_q;
                    m1_gnt_d     = win_q;
                    last_grant_d = win_q;
                    state_d      = IDLE;
                end else begin
                    merged_d    = merge_c;
                    mem_wr_en_d = 1'b1;
                    mem_wdata_d = merge_c;
                    state_d     = MERGE_WR;
                end
            end

            MERGE_WR: begin
                m0_gnt_d     = ~win_q;
                m1_gnt_d     = win_q;
                last_grant_d = win_q;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            win_q        <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            merged_q     <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            m0_gnt_q     <= 1'b0;
            m1_gnt_q     <= 1'b0;
            busy_q       <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            win_q        <= win_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            merged_q     <= merged_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            m0_gnt_q     <= m0_gnt_d;
            m1_gnt_q     <= m1_gnt_d;
            busy_q       <= busy_d;
            mem_wr_en_q  <= mem_wr_en_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Depth only bounds the memory; out-of-range word indices wrap there
    always @(posedge clk) begin
        if (!reset && (state_q == ACCESS)) begin
            assert (NUM_WORDS != 0);
        end
    end

    assign m0_gnt    = m0_gnt_q;
    assign m1_gnt    = m1_gnt_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign busy      = busy_q;
    assign mem_addr  = {waddr_q, 2'b00};
    assign mem_wdata = mem_wdata_q;
    // Reset landing in the write cycle must suppress that write, not just later ones
    assign mem_wr_en = mem_wr_en_q & ~reset;

endmodule
